// File: rtl/fpu_unit_if.sv
// fpu_unit_if
// Host-side command/result bundle for the fpu_unit coprocessor.
//   start           : level request, only looked at while the unit is idle
//   a_operand       : binary32 operand A
//   b_operand       : binary32 operand B
//   operation       : 0 add, 1 sub, 2 mul, 3 reserved
//   ieee_packet_out : binary32 result, held until the next completion
//   cmd_end         : one-cycle completion pulse
//   busy            : high while a command is in progress
// The host side uses the master modport, the arithmetic unit uses slave.
interface fpu_unit_if;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [1:0]  operation;
    logic [31:0] ieee_packet_out;
    logic        cmd_end;
    logic        busy;

    modport master (
        output start, a_operand, b_operand, operation,
        input  ieee_packet_out, cmd_end, busy
    );

    modport slave (
        input  start, a_operand, b_operand, operation,
        output ieee_packet_out, cmd_end, busy
    );
endinterface

// File: rtl/fpu_unit.sv
// fpu_unit
// Multi-cycle IEEE-754 binary32 add / subtract / multiply coprocessor with
// round-to-nearest-even and full subnormal, zero, infinity and NaN handling.
//   clk  : rising-edge system clock
//   arst : asynchronous active-low reset
//   bus  : fpu_unit_if.slave (start, operands, opcode in; result, cmd_end,
//          busy out)
// The working significand is 50 bits wide: bit 49 catches carry-out, bit 48
// is the hidden bit and bits 47:0 are fraction, so a full 24x24 product fits
// without loss and add/sub keeps 25 bits below the result LSB for rounding.
module fpu_unit (
    input  logic      clk,
    input  logic      arst,
    fpu_unit_if.slave bus
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } e_fpu_op;

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADDSUB,
        S_MULT, S_NORM, S_ROUND, S_PACK, S_DONE
    } e_state;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    e_state             state;
    e_state             state_next;

    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    e_fpu_op            op_reg;
    logic               sa;
    logic               sb;
    logic signed [10:0] ea;
    logic signed [10:0] eb;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic               a_zero;
    logic               a_inf;
    logic               a_nan;
    logic               b_zero;
    logic               b_inf;
    logic               b_nan;
    logic               rsign;
    logic signed [10:0] rexp;
    logic [49:0]        mant;
    logic [49:0]        mant_y;
    logic [10:0]        diff;
    logic               eff_sub;
    logic [31:0]        result_reg;

    logic               special_hit;
    logic [31:0]        special_val;
    logic               is_addsub;
    logic               a_ge_b;
    logic [49:0]        addsub_sum;
    logic [47:0]        product;
    logic [49:0]        norm_mant;
    logic signed [10:0] norm_exp;
    logic               norm_done;
    logic               round_up;
    logic [24:0]        rounded;
    logic [31:0]        pack_val;

    // Right shift that ORs every bit pushed out into bit 0 (sticky).
    function automatic logic [49:0] shr_sticky(input logic [49:0] v, input logic [10:0] n);
        logic [49:0] lost_mask;
        logic [49:0] r;
        lost_mask = ~({50{1'b1}} << n);
        r         = v >> n;
        r[0]      = r[0] | (|(v & lost_mask));
        return r;
    endfunction

    assign bus.busy            = (state != S_IDLE);
    assign bus.cmd_end         = (state == S_DONE);
    assign bus.ieee_packet_out = result_reg;

    assign is_addsub  = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    // {exponent, significand} orders magnitudes correctly because subnormals
    // carry exponent 1 with a zero hidden bit.
    assign a_ge_b     = {ea, ma} >= {eb, mb};
    // The larger magnitude always sits in mant, so subtraction never wraps.
    assign addsub_sum = eff_sub ? (mant - mant_y) : (mant + mant_y);
    assign product    = {24'd0, ma} * {24'd0, mb};

    // Special-case table, evaluated on the unpacked fields; first match wins.
    always_comb begin
        special_hit = 1'b1;
        special_val = QNAN;
        if (a_nan || b_nan) begin
            special_val = QNAN;
        end else if (is_addsub && a_inf && b_inf && (sa != sb)) begin
            special_val = QNAN;
        end else if ((op_reg == OP_MUL) && ((a_inf && b_zero) || (a_zero && b_inf))) begin
            special_val = QNAN;
        end else if (op_reg == OP_RSVD) begin
            special_val = QNAN;
        end else if (is_addsub && a_inf) begin
            special_val = {sa, 8'hFF, 23'd0};
        end else if (is_addsub && b_inf) begin
            special_val = {sb, 8'hFF, 23'd0};
        end else if ((op_reg == OP_MUL) && (a_inf || b_inf)) begin
            special_val = {sa ^ sb, 8'hFF, 23'd0};
        end else if ((op_reg == OP_MUL) && (a_zero || b_zero)) begin
            special_val = {sa ^ sb, 31'd0};
        end else if (is_addsub && a_zero && b_zero) begin
            // Only (-0)+(-0) stays negative under round-to-nearest.
            special_val = {sa & sb, 31'd0};
        end else if (is_addsub && a_zero) begin
            special_val = {sb, b_reg[30:0]};
        end else if (is_addsub && b_zero) begin
            special_val = {sa, a_reg[30:0]};
        end else begin
            special_hit = 1'b0;
        end
    end

    // One normalisation step. Carry-out and multiply underflow shift right;
    // a missing hidden bit shifts left but never below exponent 1. An
    // exponent of -25 or less would push every bit below the guard position,
    // so the whole significand collapses to sticky in one step.
    always_comb begin
        norm_mant = mant;
        norm_exp  = rexp;
        norm_done = 1'b0;
        if (mant[49]) begin
            norm_mant = {1'b0, mant[49:2], mant[1] | mant[0]};
            norm_exp  = rexp + 11'sd1;
        end else if (rexp < -11'sd24) begin
            norm_mant = {49'd0, |mant};
            norm_exp  = 11'sd1;
        end else if (rexp < 11'sd1) begin
            norm_mant = {1'b0, mant[49:2], mant[1] | mant[0]};
            norm_exp  = rexp + 11'sd1;
        end else if (!mant[48] && (rexp > 11'sd1) && (mant != 50'd0)) begin
            norm_mant = {mant[48:0], 1'b0};
            norm_exp  = rexp - 11'sd1;
        end else begin
            norm_done = 1'b1;
        end
    end

    // Round to nearest even: LSB at bit 25, guard at 24, sticky below.
    always_comb begin
        round_up = mant[24] & ((|mant[23:0]) | mant[25]);
        rounded  = {1'b0, mant[48:25]} + {24'd0, round_up};
    end

    // Final encoding of the rounded significand and exponent.
    always_comb begin
        if (rexp >= 11'sd255) begin
            pack_val = {rsign, 8'hFF, 23'd0};
        end else if (mant[48:25] == 24'd0) begin
            pack_val = {rsign, 31'd0};
        end else if (!mant[48]) begin
            pack_val = {rsign, 8'd0, mant[47:25]};
        end else begin
            pack_val = {rsign, rexp[7:0], mant[47:25]};
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (bus.start) state_next = S_UNPACK;
            S_UNPACK:  state_next = S_SPECIAL;
            S_SPECIAL: begin
                if (special_hit)            state_next = S_DONE;
                else if (op_reg == OP_MUL)  state_next = S_MULT;
                else                        state_next = S_ALIGN;
            end
            S_ALIGN:   state_next = S_ADDSUB;
            S_ADDSUB:  state_next = (addsub_sum == 50'd0) ? S_PACK : S_NORM;
            S_MULT:    state_next = S_NORM;
            S_NORM:    if (norm_done) state_next = S_ROUND;
            S_ROUND:   state_next = S_PACK;
            S_PACK:    state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            op_reg     <= OP_ADD;
            sa         <= 1'b0;
            sb         <= 1'b0;
            ea         <= 11'sd0;
            eb         <= 11'sd0;
            ma         <= 24'd0;
            mb         <= 24'd0;
            a_zero     <= 1'b0;
            a_inf      <= 1'b0;
            a_nan      <= 1'b0;
            b_zero     <= 1'b0;
            b_inf      <= 1'b0;
            b_nan      <= 1'b0;
            rsign      <= 1'b0;
            rexp       <= 11'sd0;
            mant       <= 50'd0;
            mant_y     <= 50'd0;
            diff       <= 11'd0;
            eff_sub    <= 1'b0;
            result_reg <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a_operand;
                        b_reg  <= bus.b_operand;
                        op_reg <= e_fpu_op'(bus.operation);
                    end
                end
                S_UNPACK: begin
                    // sb holds B's effective sign, so subtract becomes add.
                    sa     <= a_reg[31];
                    sb     <= b_reg[31] ^ (op_reg == OP_SUB);
                    ea     <= (a_reg[30:23] == 8'd0) ? 11'sd1 : $signed({3'b000, a_reg[30:23]});
                    eb     <= (b_reg[30:23] == 8'd0) ? 11'sd1 : $signed({3'b000, b_reg[30:23]});
                    ma     <= {|a_reg[30:23], a_reg[22:0]};
                    mb     <= {|b_reg[30:23], b_reg[22:0]};
                    a_zero <= (a_reg[30:0] == 31'd0);
                    b_zero <= (b_reg[30:0] == 31'd0);
                    a_inf  <= (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
                    b_inf  <= (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
                    a_nan  <= (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
                    b_nan  <= (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
                end
                S_SPECIAL: begin
                    if (special_hit) begin
                        result_reg <= special_val;
                    end else if (a_ge_b) begin
                        rsign  <= sa;
                        rexp   <= ea;
                        mant   <= {1'b0, ma, 25'd0};
                        mant_y <= {1'b0, mb, 25'd0};
                        diff   <= ea - eb;
                    end else begin
                        rsign  <= sb;
                        rexp   <= eb;
                        mant   <= {1'b0, mb, 25'd0};
                        mant_y <= {1'b0, ma, 25'd0};
                        diff   <= eb - ea;
                    end
                    eff_sub <= sa ^ sb;
                end
                S_ALIGN: begin
                    mant_y <= shr_sticky(mant_y, diff);
                end
                S_ADDSUB: begin
                    mant <= addsub_sum;
                    // Exact cancellation always yields +0.
                    if (addsub_sum == 50'd0) rsign <= 1'b0;
                end
                S_MULT: begin
                    mant  <= {product, 2'b00};
                    rexp  <= ea + eb - 11'sd127;
                    rsign <= sa ^ sb;
                end
                S_NORM: begin
                    mant <= norm_mant;
                    rexp <= norm_exp;
                end
                S_ROUND: begin
                    // A carry out of the significand is an exact power of two.
                    if (rounded[24]) begin
                        mant <= {2'b01, 48'd0};
                        rexp <= rexp + 11'sd1;
                    end else begin
                        mant <= {1'b0, rounded[23:0], 25'd0};
                    end
                end
                S_PACK: begin
                    result_reg <= pack_val;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_unit.sv
// tb_fpu_unit
// Self-checking bench for fpu_unit: a table of operand/opcode/expected
// records is driven through the host handshake, expectations are queued when
// a command is accepted and popped when cmd_end appears. Hand-written
// sequences cover the held-start handshake, back-to-back commands and a
// reset that lands in the middle of normalisation.
module tb_fpu_unit;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        bit          special;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] expected;
        bit          special;
    } sb_t;

    logic clk = 1'b0;
    logic arst;

    fpu_unit_if bus();

    fpu_unit dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Guards against a hang anywhere in the sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string what, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", what, actual, required);
        end
    endtask

    task automatic addVec(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected, input bit special);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.expected = expected; v.special = special;
        vecs.push_back(v);
    endtask

    task automatic pushExpected(input string name, input logic [31:0] expected, input bit special);
        sb_t e;
        e.name = name; e.expected = expected; e.special = special;
        sb_q.push_back(e);
    endtask

    task automatic waitCmdEnd(output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (bus.cmd_end === 1'b1) seen = 1'b1;
        end
    endtask

    // Drive one command, wait for its accept, then scramble the inputs so a
    // unit that re-samples them after accept gets caught.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = v.op;
        bus.a_operand = v.a;
        bus.b_operand = v.b;
        pushExpected(v.name, v.expected, v.special);
        @(posedge clk);
        #1;
        compare({v.name, " busy after accept"}, 32'(bus.busy), 32'd1);
        bus.start     = 1'b0;
        bus.operation = 2'($urandom_range(0, 3));
        bus.a_operand = $urandom();
        bus.b_operand = $urandom();
    endtask

    // Wait for cmd_end and check result and latency against the scoreboard.
    task automatic checkOutput();
        bit  seen;
        int  cycles;
        sb_t e;
        waitCmdEnd(seen, cycles);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: completion with no queued expectation");
            return;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: no cmd_end after %0d cycles, required cmd_end", e.name, cycles);
            return;
        end
        compare({e.name, " result"}, bus.ieee_packet_out, e.expected);
        if (e.special) begin
            compare({e.name, " latency"}, 32'(cycles), 32'd3);
        end else begin
            checks++;
            if (cycles > 40) begin
                failures++;
                $display("[TB] FAIL %s latency: got %0d cycles, required at most 40", e.name, cycles);
            end
        end
    endtask

    initial begin
        bit no_restart;
        bit saw_end;

        addVec("sub subnormal result", 2'd1, 32'h00800000, 32'h00400000, 32'h00400000, 1'b0);
        addVec("sub subnormal cancel", 2'd1, 32'h00555555, 32'h00555555, 32'h00000000, 1'b0);
        addVec("add tie to even",      2'd0, 32'h3F800000, 32'h3F8CCCCD, 32'h40066666, 1'b0);
        addVec("add plus zero",        2'd0, 32'h42168F5C, 32'h00000000, 32'h42168F5C, 1'b1);
        addVec("mul 16x32",            2'd2, 32'h41800000, 32'h42000000, 32'h44000000, 1'b0);
        addVec("sub negative result",  2'd1, 32'h3E800000, 32'h3F000000, 32'hBE800000, 1'b0);
        addVec("inf minus inf",        2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1);
        addVec("nan plus x",           2'd0, 32'h7FC00000, 32'h402DF854, 32'h7FC00000, 1'b1);
        addVec("zero times inf",       2'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1);
        addVec("neg inf plus x",       2'd0, 32'hFF800000, 32'h41200000, 32'hFF800000, 1'b1);
        addVec("x minus neg inf",      2'd1, 32'h41200000, 32'hFF800000, 32'h7F800000, 1'b1);
        addVec("neg zero plus neg zero", 2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
        addVec("reserved opcode",      2'd3, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1);
        addVec("add one plus one",     2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
        addVec("mul 1.5x2",            2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        addVec("mul overflow",         2'd2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0);
        addVec("mul to subnormal",     2'd2, 32'h00800000, 32'h3F000000, 32'h00400000, 1'b0);
        addVec("mul total underflow",  2'd2, 32'h80000001, 32'h00000001, 32'h80000000, 1'b0);
        addVec("neg x minus x",        2'd1, 32'hBF800000, 32'hBF800000, 32'h00000000, 1'b0);
        addVec("add overflow",         2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0);
        addVec("tie even stays",       2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
        addVec("tie odd rounds up",    2'd0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
        addVec("subnormals to normal", 2'd0, 32'h00400000, 32'h00400000, 32'h00800000, 1'b0);
        addVec("long left normalise",  2'd1, 32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0);

        bus.start     = 1'b0;
        bus.operation = 2'd0;
        bus.a_operand = 32'd0;
        bus.b_operand = 32'd0;
        arst          = 1'b0;

        repeat (2) @(negedge clk);
        compare("reset result",  bus.ieee_packet_out, 32'h00000000);
        compare("reset busy",    32'(bus.busy),       32'd0);
        compare("reset cmd_end", 32'(bus.cmd_end),    32'd0);
        arst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Held start: host keeps start high until it sees cmd_end.
        @(negedge clk);
        compare("hs idle busy", 32'(bus.busy), 32'd0);
        bus.start     = 1'b1;
        bus.operation = 2'd0;
        bus.a_operand = 32'h3F800000;
        bus.b_operand = 32'h40000000;
        pushExpected("hs add", 32'h40400000, 1'b0);
        @(posedge clk);
        #1;
        compare("hs busy on accept", 32'(bus.busy), 32'd1);
        bus.a_operand = 32'hDEADBEEF;
        checkOutput();
        bus.start = 1'b0;
        @(negedge clk);
        compare("hs cmd_end one cycle", 32'(bus.cmd_end),    32'd0);
        compare("hs result held",       bus.ieee_packet_out, 32'h40400000);
        compare("hs busy back to idle", 32'(bus.busy),       32'd0);
        no_restart = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.cmd_end !== 1'b0) no_restart = 1'b0;
        end
        compare("hs no second operation", 32'(no_restart), 32'd1);

        // Back-to-back: start stays high across DONE, so IDLE accepts again.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = 2'd0;
        bus.a_operand = 32'h3F800000;
        bus.b_operand = 32'h3F800000;
        pushExpected("b2b first", 32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput();
        bus.operation = 2'd2;
        bus.a_operand = 32'h40000000;
        bus.b_operand = 32'h40400000;
        pushExpected("b2b second", 32'h40C00000, 1'b0);
        @(negedge clk);
        compare("b2b idle gap busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        compare("b2b second accept busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        checkOutput();

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = 2'd1;
        bus.a_operand = 32'h3F800000;
        bus.b_operand = 32'h3F7FFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        arst = 1'b0;
        #1;
        compare("mid reset result",  bus.ieee_packet_out, 32'h00000000);
        compare("mid reset busy",    32'(bus.busy),       32'd0);
        compare("mid reset cmd_end", 32'(bus.cmd_end),    32'd0);
        @(negedge clk);
        arst = 1'b1;
        saw_end = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.cmd_end !== 1'b0) saw_end = 1'b1;
        end
        compare("mid reset no cmd_end",  32'(saw_end),       32'd0);
        compare("mid reset result kept", bus.ieee_packet_out, 32'h00000000);
        begin
            vec_t v;
            v.name = "post reset add"; v.op = 2'd0; v.a = 32'h3F800000; v.b = 32'h3F800000;
            v.expected = 32'h40000000; v.special = 1'b0;
            applyStimulus(v);
            checkOutput();
        end

        compare("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_unit.md
# fpu_unit

Single-precision (IEEE-754 binary32) floating-point arithmetic unit performing add, subtract and multiply. It is a multi-cycle coprocessor block: the host presents two operands and an opcode, raises `start`, and waits for a one-cycle `cmd_end` completion pulse. The result is then held on `ieee_packet_out` until the next operation completes. Normals, subnormals, zeros, infinities and NaNs are fully supported, with round-to-nearest-even.

## Interface
- No parameters.
- `clk` in 1: single system clock, rising-edge.
- `arst` in 1: asynchronous, active-low reset.
- `start` in 1: level request; sampled only in IDLE.
- `a_operand` in 32: binary32 operand A, latched on accept.
- `b_operand` in 32: binary32 operand B, latched on accept.
- `operation` in 2: `pa_fpu::e_fpu_op`; `op_add`=0 (A+B), `op_sub`=1 (A−B), `op_mul`=2 (A×B), 3 reserved.
- `ieee_packet_out` out 32: result register.
- `cmd_end` out 1: one-cycle completion pulse (end of command / IRQ).
- `busy` out 1: high while an operation is in progress.

## Operation
- States:
  - IDLE: if `start`=1, latch operands and opcode, then go to UNPACK.
  - UNPACK: split sign, exponent and mantissa. Subnormals get exponent 1 and hidden bit 0. Classify zero / inf / NaN.
  - SPECIAL: if the special-case table applies, write the result and go to DONE. Otherwise go to ALIGN (add/sub) or MULT.
  - ALIGN: right-shift the smaller-exponent mantissa, keeping guard, round and sticky bits.
  - ADDSUB: magnitude add or subtract. The effective sign comes from the larger magnitude.
  - MULT: 24×24 product; exponent = ea+eb−127.
  - NORM: shift left or right one bit per cycle until the hidden bit is at bit 23. Stop left shifts at exponent 1 (gradual underflow into subnormal).
  - ROUND: round-to-nearest-even using guard/round/sticky. Renormalize on mantissa carry-out.
  - PACK: assemble the result. Exponent ≥255 gives ±inf (0x7F800000 | sign). Hidden bit 0 at exponent 1 gives a subnormal (exponent field 0). Zero magnitude gives a zero.
  - DONE: pulse `cmd_end`, then go to IDLE.
- `op_sub` is `op_add` with B's sign inverted.
- Special-case table, first match wins:
  - Any NaN input → 0x7FC00000.
  - inf − inf (effective) → 0x7FC00000.
  - inf × 0 → 0x7FC00000.
  - Reserved opcode → 0x7FC00000.
  - inf in add/sub → that inf with its effective sign.
  - inf in mul → inf with sign sa^sb.
  - 0 × finite → zero with sign sa^sb.
  - Add with one zero operand → the other operand, with sign per effective op.
- Signed zeros:
  - Exact cancellation (x−x) → +0.
  - (−0)+(−0) → −0.
- Mul underflow: when the biased exponent ≤0, right-shift the mantissa with sticky until the exponent is 1, then round. A total underflow → signed zero.
- Status flags are not generated.

## Timing
- Reset (arst=0, async):
  - State IDLE.
  - `ieee_packet_out`=0x00000000.
  - `cmd_end`=0.
  - `busy`=0.
  - Internal registers cleared.
  - Reset mid-operation aborts the operation with no `cmd_end`.
- Accept: on the clk edge where state=IDLE and `start`=1. Operand or opcode changes after accept are ignored.
- `busy`: rises on the edge that accepts. It is high in every non-IDLE state including DONE and falls when IDLE is re-entered.
- Result update: `ieee_packet_out` is written at PACK (or SPECIAL) and is stable no later than the edge that raises `cmd_end`. It holds until the next result.
- `cmd_end`: high for exactly one cycle (the DONE state).
- Back-to-back: if `start` is still 1 in IDLE after DONE, a new operation is accepted. Host drops `start` on seeing `cmd_end`.
- Latency from accept to `cmd_end`:
  - Special case: 3 cycles.
  - Normal path: ≤ 40 cycles.
  - Latency is data-dependent (NORM iterations); the bench must wait on `cmd_end`, not count cycles.

## Test plan
- sub 0x00800000 − 0x00400000 → 0x00400000 (subnormal result). Also sub 0x00555555 − 0x00555555 → 0x00000000.
- add 0x3F800000 + 0x3F8CCCCD → 0x40066666 (tie rounds to even). Also add 0x42168F5C + 0x00000000 → 0x42168F5C.
- mul 0x41800000 × 0x42000000 → 0x44000000. Also sub 0x3E800000 − 0x3F000000 → 0xBE800000.
- Specials:
  - sub 0x7F800000 − 0x7F800000 → 0x7FC00000.
  - add 0x7FC00000 + 0x402DF854 → 0x7FC00000.
  - mul 0x00000000 × 0x7F800000 → 0x7FC00000.
  - add 0xFF800000 + 0x41200000 → 0xFF800000.
  - sub 0x41200000 − 0xFF800000 → 0x7F800000.
- Handshake: hold `start`, then check `busy` rises on accept, `cmd_end` lasts exactly one cycle, and the output is stable once `cmd_end` is seen. Drop `start` on `cmd_end` and check no second operation starts.
- Reset mid-operation: assert arst during NORM. Check all outputs are 0 immediately (asynchronously), no `cmd_end`, and that a following add 0x3F800000 + 0x3F800000 → 0x40000000 completes correctly.
